// File: rtl/fsm_010_arbiter_if.sv
// Request/grant bundle and detection outputs for the time-shared 010 detector.
// master = requesters side, slave = arbiter side.
interface fsm_010_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 10
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] x_in;
    logic [NUM_CH-1:0] gnt;
    logic              y;
    logic [CH_W-1:0]   y_ch;
    logic [CNT_W-1:0]  users_count;

    modport master (
        output req, x_in,
        input  gnt, y, y_ch, users_count
    );

    modport slave (
        input  req, x_in,
        output gnt, y, y_ch, users_count
    );
endinterface

// File: rtl/fsm_010_arbiter.sv
// Round-robin shares one 010 detector across NUM_CH channels; y/y_ch/users_count update at the consuming edge.
// Ungranted requesters hold x_in until gnt (gnt is their backpressure); define USERS_SAT_EN to saturate users_count.
module fsm_010_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 10
) (
    input  logic                clk,
    input  logic                rst,
    fsm_010_arbiter_if.slave    bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S0   = 2'd1,
        S01  = 2'd2
    } state_t;

    state_t            ch_state [NUM_CH];
    logic [CH_W-1:0]   rr_ptr;
    logic              y_q;
    logic [CH_W-1:0]   y_ch_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [NUM_CH-1:0] gnt_vec;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              x_sel;
    logic              detect;
    logic [CH_W-1:0]   rr_next;
    logic [CNT_W-1:0]  cnt_next;

    function automatic state_t next_state(input state_t s, input logic x);
        case (s)
            IDLE:    return x ? IDLE : S0;
            S0:      return x ? S01  : S0;
            S01:     return x ? IDLE : S0;
            default: return IDLE;
        endcase
    endfunction

    // Cyclic search starting at rr_ptr; nothing is granted while in reset.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vec = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                idx = (int'(rr_ptr) + i) % NUM_CH;
                if (!gnt_any && bus.req[idx]) begin
                    gnt_any      = 1'b1;
                    gnt_idx      = CH_W'(idx);
                    gnt_vec[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        x_sel   = bus.x_in[gnt_idx];
        detect  = gnt_any && (ch_state[gnt_idx] == S01) && !x_sel;
        rr_next = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
`ifdef USERS_SAT_EN
        cnt_next = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
`else
        cnt_next = cnt_q + 1'b1;
`endif
    end

    // Only the granted channel's context advances; all others hold indefinitely.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_state[i] <= IDLE;
            end
            rr_ptr <= '0;
            y_q    <= 1'b0;
            y_ch_q <= '0;
            cnt_q  <= '0;
        end else begin
            y_q <= 1'b0;
            if (gnt_any) begin
                ch_state[gnt_idx] <= next_state(ch_state[gnt_idx], x_sel);
                rr_ptr            <= rr_next;
                if (detect) begin
                    y_q    <= 1'b1;
                    y_ch_q <= gnt_idx;
                    cnt_q  <= cnt_next;
                end
            end
        end
    end

    assign bus.gnt         = gnt_vec;
    assign bus.y           = y_q;
    assign bus.y_ch        = y_ch_q;
    assign bus.users_count = cnt_q;
endmodule

// File: tb/tb_fsm_010_arbiter.sv
// Randomized + directed bench: reference model tracks per-channel bit history and a round-robin pointer.
module tb_fsm_010_arbiter;
    localparam int N  = 4;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fsm_010_arbiter_if #(.NUM_CH(N), .CNT_W(CW)) bus ();
    fsm_010_arbiter #(.NUM_CH(N), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int edge_n;
        bit y;
        int ch;
        int cnt;
    } exp_t;

    exp_t     sb [$];
    bit       chq [N][$];
    int       total = 0;
    int       bad = 0;
    int       edge_no = 0;
    int       m_rr = 0;
    int       m_cnt = 0;
    int       m_ch = 0;
    logic [2:0] m_hist [N];
    int       m_len [N];

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pending_cnt();
        int s = 0;
        for (int i = 0; i < N; i++) s += chq[i].size();
        return s;
    endfunction

    task automatic load(input int ch, input int len, input logic [31:0] pat);
        for (int b = len - 1; b >= 0; b--) chq[ch].push_back(pat[b]);
    endtask

    // One cycle: drive at negedge, check gnt, advance model, queue expected post-edge outputs.
    task automatic step(input bit r, input logic [N-1:0] rq, input logic [N-1:0] xv, output int k);
        logic [N-1:0] egnt;
        exp_t e;
        int idx;
        rst      = r;
        bus.req  = rq;
        bus.x_in = xv;
        #1;
        k    = -1;
        egnt = '0;
        if (!r) begin
            for (int i = 0; i < N; i++) begin
                idx = (m_rr + i) % N;
                if (k < 0 && rq[idx]) k = idx;
            end
        end
        if (k >= 0) egnt[k] = 1'b1;
        chk("gnt", 32'(bus.gnt), int'(egnt));
        e.edge_n = edge_no + 1;
        e.y      = 1'b0;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_hist[i] = '0;
                m_len[i]  = 0;
            end
            m_rr  = 0;
            m_cnt = 0;
            m_ch  = 0;
        end else if (k >= 0) begin
            m_hist[k] = {m_hist[k][1:0], xv[k]};
            if (m_len[k] < 3) m_len[k]++;
            m_rr = (k + 1) % N;
            if (m_len[k] >= 3 && m_hist[k] == 3'b010) begin
                e.y  = 1'b1;
                m_ch = k;
`ifdef USERS_SAT_EN
                if (m_cnt < (1 << CW) - 1) m_cnt++;
`else
                m_cnt = (m_cnt + 1) % (1 << CW);
`endif
            end
        end
        e.ch  = m_ch;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_q(input int maxc, input int req_pct, input int rst_pmil);
        int c = 0;
        int k;
        logic [N-1:0] rq;
        logic [N-1:0] xv;
        bit r;
        while (pending_cnt() > 0 && c < maxc) begin
            for (int i = 0; i < N; i++) begin
                if (chq[i].size() > 0) begin
                    xv[i] = chq[i][0];
                    rq[i] = ($urandom_range(99) < req_pct);
                end else begin
                    xv[i] = 1'($urandom_range(1));
                    rq[i] = 1'b0;
                end
            end
            r = ($urandom_range(999) < rst_pmil);
            step(r, rq, xv, k);
            if (k >= 0) void'(chq[k].pop_front());
            c++;
        end
        chk("drain_pending", 32'(pending_cnt()), 0);
        for (int i = 0; i < N; i++) chq[i].delete();
    endtask

    task automatic do_reset();
        int k;
        step(1'b1, '1, '0, k);
    endtask

    // Monitor: compares registered outputs shortly after every edge that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edge_no++;
            #2;
            if (sb.size() > 0 && sb[0].edge_n == edge_no) begin
                e = sb.pop_front();
                chk("y", 32'(bus.y), int'(e.y));
                chk("y_ch", 32'(bus.y_ch), e.ch);
                chk("users_count", 32'(bus.users_count), e.cnt);
            end
        end
    end

    initial begin
        int k;
        for (int i = 0; i < N; i++) begin
            m_hist[i] = '0;
            m_len[i]  = 0;
        end
        bus.req  = '0;
        bus.x_in = '0;
        @(negedge clk);
        step(1'b1, '0, '0, k);
        step(1'b1, '1, '1, k);

        // ch0 only, single detection then overlapping pair
        load(0, 3, 32'b010);
        run_q(20, 100, 0);
        load(0, 5, 32'b01010);
        run_q(20, 100, 0);

        // all channels streaming 0,1,0 from a fresh pointer
        do_reset();
        for (int ch = 0; ch < N; ch++) load(ch, 3, 32'b010);
        run_q(40, 100, 0);

        // isolation: interleaved bits of different channels never combine
        do_reset();
        load(0, 1, 32'b0);
        load(1, 1, 32'b1);
        load(2, 1, 32'b0);
        run_q(20, 100, 0);
        load(0, 2, 32'b10);
        run_q(20, 100, 0);

        // reset mid-sequence; bit presented during reset is not consumed; pointer restarts at 0
        step(1'b0, 4'b0010, 4'b0000, k);
        step(1'b0, 4'b0010, 4'b0010, k);
        step(1'b1, 4'b0010, 4'b0000, k);
        step(1'b0, 4'b0011, 4'b0000, k);
        step(1'b0, 4'b0010, 4'b0000, k);

        // randomized traffic with dropping requests and occasional resets
        for (int ch = 0; ch < N; ch++) begin
            for (int b = 0; b < 60; b++) chq[ch].push_back(1'($urandom_range(1)));
        end
        run_q(3000, 70, 3);

        // counter boundary: 1024 overlapping detections on ch2
        do_reset();
        load(2, 1, 32'b0);
        for (int d = 0; d < 1024; d++) load(2, 2, 32'b10);
        run_q(3000, 100, 0);

        for (int i = 0; i < 3; i++) step(1'b0, '0, 4'($urandom_range(15)), k);
        @(negedge clk);
        @(negedge clk);
        chk("sb_leftover", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
